gradient_magnitude: RTL and testbench

GRADIENT_MAGNITUDE -- requirements
Module: gradient_magnitude

---
 rtl/gradient_magnitude_pkg.sv | 23 ++
 rtl/gradient_magnitude_abs_diff_u8.sv | 23 ++
 rtl/gradient_magnitude.sv | 224 ++++++++++++++++++++++
 tb/tb_gradient_magnitude.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gradient_magnitude_pkg.sv
// Shared constants and helpers for the gradient magnitude pipeline.
//   PIX_W          pixel / gradient width (uint8)
//   GRAD_MAX       largest representable gradient
//   LINE_WIDTH_DEF default pixels per line
//   SKIP_COLS_DEF  default count of leading columns forced to zero gradient
//   sat_add        unsigned add clamped to GRAD_MAX
package gradient_magnitude_pkg;

    localparam int PIX_W          = 8;
    localparam int GRAD_MAX       = 255;
    localparam int LINE_WIDTH_DEF = 640;
    localparam int LINE_WIDTH_MAX = 4096;
    localparam int SKIP_COLS_DEF  = 2;

    typedef logic [PIX_W-1:0] pix_t;

    function automatic pix_t sat_add(input pix_t a, input pix_t b);
        logic [PIX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[PIX_W] ? pix_t'(GRAD_MAX) : sum[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/gradient_magnitude_abs_diff_u8.sv
// Combinational absolute difference of two uint8 values.
//   a, b : uint8 operands
//   y    : |a - b|, 0..255
// The subtraction is done as a 9-bit signed value so the full -255..255
// range is representable before the magnitude is taken.
module abs_diff_u8
    import gradient_magnitude_pkg::*;
(
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    output logic [PIX_W-1:0] y
);

    logic signed [PIX_W:0] diff;
    logic signed [PIX_W:0] diff_neg;

    always_comb begin
        diff     = $signed({1'b0, a}) - $signed({1'b0, b});
        diff_neg = -diff;
        y        = diff[PIX_W] ? diff_neg[PIX_W-1:0] : diff[PIX_W-1:0];
    end

endmodule

// File: rtl/gradient_magnitude.sv
// Streaming gradient magnitude for a uint8 greyscale pixel stream.
// Two-stage pipeline: stage 1 registers |p[c]-p[c-2]| (and the vertical term
// when enabled), stage 2 applies the start-of-line suppression and sum.
//
// Ports
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   enb             clock enable, low stalls every register
//   pix_in          uint8 pixel
//   pix_valid       pix_in valid this cycle
//   line_start      first pixel of a line (sampled with pix_valid)
//   grad_out        uint8 gradient magnitude
//   grad_valid      grad_out valid this cycle (forced low while stalled)
//   grad_line_start line_start delayed in step with grad_out
//   err_overrun     sticky: a line ran past LINE_WIDTH pixels
//
// Build option
//   GRAD_VERTICAL_EN  adds a one-line buffer and the vertical term
//                     |p[r][c]-p[r-1][c]|, summed with saturation.
module gradient_magnitude
    import gradient_magnitude_pkg::*;
#(
    parameter int LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int SKIP_COLS  = SKIP_COLS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             line_start,
    output logic [PIX_W-1:0] grad_out,
    output logic             grad_valid,
    output logic             grad_line_start,
    output logic             err_overrun
);

    localparam int                COL_W    = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(LINE_WIDTH - 1);

    logic             accept;
    logic             first_pix;
    logic [COL_W-1:0] col_cur;
    logic             skip_cur;
    pix_t             hist1;
    pix_t             hist2;
    pix_t             dx;
    pix_t             grad_sum;

    // column / history state
    logic             started_q, started_d;
    logic [COL_W-1:0] col_q, col_d;
    pix_t             tap1_q, tap1_d;
    pix_t             tap2_q, tap2_d;
    logic             err_q, err_d;

    // stage 1
    logic             s1_valid_q, s1_valid_d;
    logic             s1_ls_q, s1_ls_d;
    logic             s1_skip_q, s1_skip_d;
    pix_t             s1_dx_q, s1_dx_d;

    // stage 2 (outputs)
    pix_t             grad_q, grad_d;
    logic             gvalid_q, gvalid_d;
    logic             gls_q, gls_d;

`ifdef GRAD_VERTICAL_EN
    pix_t             line_buf_q [LINE_WIDTH];
    pix_t             above;
    pix_t             dy_raw;
    pix_t             dy;
    logic             row_prev_q, row_prev_d;
    pix_t             s1_dy_q, s1_dy_d;
`endif

    assign accept = enb & pix_valid;

    // Until the first pixel after reset is seen, the column counter's 0 does
    // not yet describe a real pixel, so that pixel is also a column 0.
    assign first_pix = line_start | ~started_q;

    always_comb begin
        if (first_pix) begin
            col_cur = '0;
        end else if (col_q == COL_LAST) begin
            col_cur = COL_LAST;
        end else begin
            col_cur = col_q + 1'b1;
        end
    end

    assign skip_cur = (int'(col_cur) < SKIP_COLS);

    // History of the previous line never reaches the difference.
    assign hist1 = first_pix ? '0 : tap1_q;
    assign hist2 = first_pix ? '0 : tap2_q;

    abs_diff_u8 u_dx (
        .a (pix_in),
        .b (hist2),
        .y (dx)
    );

`ifdef GRAD_VERTICAL_EN
    assign above = line_buf_q[col_cur];

    abs_diff_u8 u_dy (
        .a (pix_in),
        .b (above),
        .y (dy_raw)
    );

    // The buffer holds garbage until a full line has been written after reset.
    assign dy = row_prev_q ? dy_raw : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            line_buf_q[col_cur] <= pix_in;
        end
    end

    assign grad_sum = sat_add(s1_dx_q, s1_dy_q);
`else
    assign grad_sum = s1_dx_q;
`endif

    always_comb begin
        started_d  = started_q;
        col_d      = col_q;
        tap1_d     = tap1_q;
        tap2_d     = tap2_q;
        err_d      = err_q;
        s1_valid_d = s1_valid_q;
        s1_ls_d    = s1_ls_q;
        s1_skip_d  = s1_skip_q;
        s1_dx_d    = s1_dx_q;
        grad_d     = grad_q;
        gvalid_d   = gvalid_q;
        gls_d      = gls_q;
`ifdef GRAD_VERTICAL_EN
        row_prev_d = row_prev_q;
        s1_dy_d    = s1_dy_q;
`endif

        if (accept) begin
            started_d = 1'b1;
            col_d     = col_cur;
            tap1_d    = pix_in;
            tap2_d    = hist1;
            if (!line_start && started_q && (col_q == COL_LAST)) begin
                err_d = 1'b1;
            end
`ifdef GRAD_VERTICAL_EN
            if (line_start && started_q) begin
                row_prev_d = 1'b1;
            end
`endif
        end

        if (enb) begin
            s1_valid_d = pix_valid;
            if (pix_valid) begin
                s1_ls_d   = line_start;
                s1_skip_d = skip_cur;
                s1_dx_d   = dx;
`ifdef GRAD_VERTICAL_EN
                s1_dy_d   = dy;
`endif
            end
            gvalid_d = s1_valid_q;
            gls_d    = s1_valid_q & s1_ls_q;
            if (s1_valid_q) begin
                grad_d = s1_skip_q ? '0 : grad_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started_q  <= 1'b0;
            col_q      <= '0;
            tap1_q     <= '0;
            tap2_q     <= '0;
            err_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_ls_q    <= 1'b0;
            s1_skip_q  <= 1'b0;
            s1_dx_q    <= '0;
            grad_q     <= '0;
            gvalid_q   <= 1'b0;
            gls_q      <= 1'b0;
`ifdef GRAD_VERTICAL_EN
            row_prev_q <= 1'b0;
            s1_dy_q    <= '0;
`endif
        end else begin
            started_q  <= started_d;
            col_q      <= col_d;
            tap1_q     <= tap1_d;
            tap2_q     <= tap2_d;
            err_q      <= err_d;
            s1_valid_q <= s1_valid_d;
            s1_ls_q    <= s1_ls_d;
            s1_skip_q  <= s1_skip_d;
            s1_dx_q    <= s1_dx_d;
            grad_q     <= grad_d;
            gvalid_q   <= gvalid_d;
            gls_q      <= gls_d;
`ifdef GRAD_VERTICAL_EN
            row_prev_q <= row_prev_d;
            s1_dy_q    <= s1_dy_d;
`endif
        end
    end

    // A stalled cycle is not a transfer; the held result is presented again
    // on the enabled cycle that actually consumes it.
    assign grad_out        = grad_q;
    assign grad_valid      = gvalid_q & enb;
    assign grad_line_start = gls_q;
    assign err_overrun     = err_q;

endmodule

// File: tb/tb_gradient_magnitude.sv
module tb_gradient_magnitude;

    localparam int LW = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       enb;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       line_start;
    logic [7:0] grad_out;
    logic       grad_valid;
    logic       grad_line_start;
    logic       err_overrun;

    int checks   = 0;
    int failures = 0;
    int ecnt     = 0;
    int exp_q[$];
    int exp_ls_q[$];
    int acc_q[$];

    always #5 clk = ~clk;

    gradient_magnitude #(
        .LINE_WIDTH (LW),
        .SKIP_COLS  (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enb             (enb),
        .pix_in          (pix_in),
        .pix_valid       (pix_valid),
        .line_start      (line_start),
        .grad_out        (grad_out),
        .grad_valid      (grad_valid),
        .grad_line_start (grad_line_start),
        .err_overrun     (err_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Output monitor: values, line_start alignment and latency in enabled cycles.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (!enb) chk("stall_valid", {31'd0, grad_valid}, 0);
            if (grad_valid === 1'b1) begin
                chk("out_pending", {31'd0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) begin
                    chk("grad_out", {24'd0, grad_out}, exp_q.pop_front());
                    chk("grad_ls", {31'd0, grad_line_start}, exp_ls_q.pop_front());
                    chk("latency", ecnt - acc_q.pop_front(), 2);
                end
            end
            if (enb && pix_valid) acc_q.push_back(ecnt);
            if (enb) ecnt++;
        end
    end

    task automatic px(input int p, input bit ls, input int e);
        enb        = 1'b1;
        pix_valid  = 1'b1;
        line_start = ls;
        pix_in     = 8'(p);
        exp_q.push_back(e);
        exp_ls_q.push_back(int'(ls));
        @(posedge clk); #1;
    endtask

    task automatic stall(input int n);
        enb        = 1'b0;
        pix_valid  = 1'b1;
        line_start = 1'b1;
        pix_in     = 8'd99;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic gap(input int n);
        enb        = 1'b1;
        pix_valid  = 1'b0;
        line_start = 1'b1;
        pix_in     = 8'd77;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string tag);
        gap(4);
        chk(tag, exp_q.size(), 0);
        exp_q.delete();
        exp_ls_q.delete();
        acc_q.delete();
    endtask

    task automatic do_reset();
        #2;
        reset     = 1'b0;
        enb       = 1'b1;
        pix_valid = 1'b0;
        exp_q.delete();
        exp_ls_q.delete();
        acc_q.delete();
        #1;
        chk("rst_grad_out", {24'd0, grad_out}, 0);
        chk("rst_grad_valid", {31'd0, grad_valid}, 0);
        chk("rst_grad_ls", {31'd0, grad_line_start}, 0);
        chk("rst_err", {31'd0, err_overrun}, 0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        enb        = 1'b0;
        pix_valid  = 1'b0;
        line_start = 1'b0;
        pix_in     = 8'd0;
        #1;
        reset = 1'b0;
        #2;
        chk("init_grad_out", {24'd0, grad_out}, 0);
        chk("init_grad_valid", {31'd0, grad_valid}, 0);
        chk("init_grad_ls", {31'd0, grad_line_start}, 0);
        chk("init_err", {31'd0, err_overrun}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // step edge line
        px(10, 1, 0); px(10, 0, 0); px(10, 0, 0);
        px(50, 0, 40); px(50, 0, 40); px(50, 0, 0);
        drain("drain_step");

        // full-scale differences, no wraparound
        do_reset();
        px(0, 1, 0); px(0, 0, 0); px(200, 0, 200);
        drain("drain_200");
        do_reset();
        px(255, 1, 0); px(255, 0, 0); px(0, 0, 255);
        drain("drain_255");

        // one-pixel lines
        do_reset();
        px(100, 1, 0); px(200, 1, 0); px(50, 1, 0); px(250, 1, 0);
        drain("drain_1px");
        chk("err_1px", {31'd0, err_overrun}, 0);

        // stall mid-line with pix_valid held high
        do_reset();
        px(10, 1, 0); px(20, 0, 0); px(30, 0, 20);
        stall(3);
        px(70, 0, 50); px(90, 0, 60);
        drain("drain_stall");

        // exactly LW pixels then a new line: no overrun
        do_reset();
        px(1, 1, 0); px(2, 0, 0);
        for (int k = 3; k <= LW; k++) px(k, 0, 2);
        px(9, 1, 0);
        drain("drain_exact");
        chk("err_exact_line", {31'd0, err_overrun}, 0);

        // reset mid-line discards in-flight data; next pixel is column 0
        do_reset();
        px(30, 1, 0); px(60, 0, 0); px(200, 0, 170); px(90, 0, 30);
        do_reset();
        px(5, 0, 0); px(5, 0, 0); px(100, 0, 95);
        drain("drain_after_rst");

        // overrun: LW+1 pixels with no line_start after reset
        do_reset();
        for (int k = 0; k < LW; k++) px(10 * k, 0, (k < 2) ? 0 : 20);
        chk("err_before", {31'd0, err_overrun}, 0);
        px(10 * LW, 0, 20);
        chk("err_set", {31'd0, err_overrun}, 1);
        px(3, 1, 0); px(4, 0, 0);
        drain("drain_ovr");
        chk("err_sticky", {31'd0, err_overrun}, 1);
        do_reset();

`ifdef GRAD_VERTICAL_EN
        // vertical term and saturation
        do_reset();
        for (int c = 0; c < LW; c++) px(0, c == 0, 0);
        for (int c = 0; c < LW; c++) px(200, c == 0, (c < 2) ? 0 : 200);
        px(0, 1, 0); px(0, 0, 0); px(255, 0, 255);
        drain("drain_vert");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
